seg_scan_nco_disp: RTL and testbench

Parametrised multi-digit 7-segment scan driver, generalising the fixed 6-digit count display.
- An internal NCO accumulator generates the digit-scan tick.
- N_DIGIT hex digits are time-multiplexed onto one segment bus.
- Adds double-buffered digit loading, leading-zero blanking, per-digit decimal points and PWM brightness.
- Sits between the counter/time datapath and the board segment pins.

---
 rtl/seg_disp_pkg.sv | 28 ++
 rtl/seg_hex_decoder.sv | 18 +
 rtl/seg_scan_nco_disp.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_nco_disp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
//------------------------------------------------------------------------------
// seg_disp_pkg : shared constants for the 7-segment scan display
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_disp_pkg;

  // Segment bit positions on the o_seg bus
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex glyphs 0..F, indexed by nibble value
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

`default_nettype wire

// File: rtl/seg_hex_decoder.sv
//------------------------------------------------------------------------------
// seg_hex_decoder : combinational hex nibble to 7-segment glyph
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_hex_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_CODES[i_nib];

endmodule

`default_nettype wire

// File: rtl/seg_scan_nco_disp.sv
//------------------------------------------------------------------------------
// seg_scan_nco_disp : NCO-paced multi-digit 7-segment scan driver with
// double-buffered load, leading-zero blanking and PWM (macro SEG_DISP_PWM_EN)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_nco_disp
  import seg_disp_pkg::*;
#(
  parameter int N_DIGIT = 6,
  parameter int NCO_W   = 32,
  parameter int PWM_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*N_DIGIT-1:0]   i_digits,
  input  logic [N_DIGIT-1:0]     i_dp,
  input  logic                   i_load,
  input  logic                   i_blank_lz,
  input  logic [NCO_W-1:0]       i_nco_num,
  input  logic [PWM_W-1:0]       i_bright,
  output logic [N_DIGIT-1:0]     o_seg_enb,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic                   o_frame_done
);

  localparam int IDX_W = $clog2(N_DIGIT);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_DIGIT - 1);

  logic [NCO_W-1:0]     r_acc;
  logic [IDX_W-1:0]     r_idx;
  logic [4*N_DIGIT-1:0] r_pend_digits;
  logic [N_DIGIT-1:0]   r_pend_dp;
  logic                 r_pend_flag;
  logic [4*N_DIGIT-1:0] r_disp_digits;
  logic [N_DIGIT-1:0]   r_disp_dp;
  logic [N_DIGIT-1:0]   r_seg_enb;
  logic [6:0]           r_seg;
  logic                 r_seg_dp;
  logic                 r_frame_done;

  logic [NCO_W:0]       w_sum;
  logic                 w_tick;
  logic                 w_wrap;
  logic [3:0]           w_nib;
  logic [6:0]           w_seg;
  logic                 w_dp_cur;
  logic [N_DIGIT-1:0]   w_lz;
  logic                 w_lz_run;
  logic                 w_blank;
  logic [N_DIGIT-1:0]   w_enb;
  logic                 w_on;

  // Scan tick is the carry out of the phase accumulator
  assign w_sum  = {1'b0, r_acc} + {1'b0, i_nco_num};
  assign w_tick = w_sum[NCO_W];
  assign w_wrap = w_tick && (r_idx == c_last_idx);

  assign w_nib    = r_disp_digits[{r_idx, 2'b00} +: 4];
  assign w_dp_cur = r_disp_dp[r_idx];
  assign w_enb    = N_DIGIT'(1) << r_idx;

  seg_hex_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // w_lz[k]: digit k and every digit above it are zero with no dp lit
  always_comb begin
    w_lz     = '0;
    w_lz_run = 1'b1;
    for (int k = N_DIGIT - 1; k >= 0; k--) begin
      w_lz_run = w_lz_run && (r_disp_digits[4*k +: 4] == 4'h0) && !r_disp_dp[k];
      w_lz[k]  = w_lz_run;
    end
  end

  assign w_blank = i_blank_lz && w_lz[r_idx] && (r_idx != '0);

`ifdef SEG_DISP_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  assign w_on = (r_pwm_cnt < i_bright) || (&i_bright);
`else
  logic w_unused_bright;
  assign w_unused_bright = ^i_bright;
  assign w_on            = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      r_acc <= w_sum[NCO_W-1:0];
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // A load coinciding with the wrap bypasses the pending buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_flag   <= 1'b0;
      r_disp_digits <= '0;
      r_disp_dp     <= '0;
    end else if (w_wrap) begin
      r_pend_flag <= 1'b0;
      if (i_load) begin
        r_disp_digits <= i_digits;
        r_disp_dp     <= i_dp;
      end else if (r_pend_flag) begin
        r_disp_digits <= r_pend_digits;
        r_disp_dp     <= r_pend_dp;
      end
    end else if (i_load) begin
      r_pend_digits <= i_digits;
      r_pend_dp     <= i_dp;
      r_pend_flag   <= 1'b1;
    end
  end

  // While the PWM phase is off only the enables drop; segments keep their value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_enb    <= '0;
      r_seg        <= SEG_BLANK;
      r_seg_dp     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_on) begin
        r_seg_enb <= w_enb;
        r_seg     <= w_blank ? SEG_BLANK : w_seg;
        r_seg_dp  <= w_blank ? 1'b0 : w_dp_cur;
      end else begin
        r_seg_enb <= '0;
      end
    end
  end

  assign o_seg_enb    = r_seg_enb;
  assign o_seg        = r_seg;
  assign o_seg_dp     = r_seg_dp;
  assign o_frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_nco_disp.sv
//------------------------------------------------------------------------------
// tb_seg_scan_nco_disp : directed self-checking bench for seg_scan_nco_disp
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_nco_disp;

  localparam int N  = 6;
  localparam int NW = 32;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*N-1:0]  i_digits;
  logic [N-1:0]    i_dp;
  logic            i_load;
  logic            i_blank_lz;
  logic [NW-1:0]   i_nco_num;
  logic [PW-1:0]   i_bright;
  logic [N-1:0]    o_seg_enb;
  logic [6:0]      o_seg;
  logic            o_seg_dp;
  logic            o_frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0]   cap_seg [N];
  logic [N-1:0] cap_enb [N];
  logic         cap_dp  [N];

  seg_scan_nco_disp #(.N_DIGIT(N), .NCO_W(NW), .PWM_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_load       (i_load),
    .i_blank_lz   (i_blank_lz),
    .i_nco_num    (i_nco_num),
    .i_bright     (i_bright),
    .o_seg_enb    (o_seg_enb),
    .o_seg        (o_seg),
    .o_seg_dp     (o_seg_dp),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (o_frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p);
    i_digits = d;
    i_dp     = p;
    i_load   = 1'b1;
    @(negedge clk);
    i_load   = 1'b0;
  endtask

  // Samples each digit slot in the frame after the next wrap (4 clks per slot)
  task automatic cap_frame();
    wait_frame();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      cap_seg[k] = o_seg;
      cap_enb[k] = o_seg_enb;
      cap_dp[k]  = o_seg_dp;
      if (k < N - 1) repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7*N-1:0] segs, input logic [N-1:0] dps);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_seg%0d", tag, k), 32'(cap_seg[k]), 32'(segs[7*k +: 7]));
      check($sformatf("%s_dp%0d", tag, k), 32'(cap_dp[k]), 32'(dps[k]));
      check($sformatf("%s_enb%0d", tag, k), 32'(cap_enb[k]), 32'(1 << k));
    end
  endtask

  task automatic count_on(output int cnt);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_seg_enb != '0) cnt++;
    end
  endtask

  initial begin
    int n;
    logic [N-1:0] e;
    rst        = 1'b1;
    i_digits   = '0;
    i_dp       = '0;
    i_load     = 1'b0;
    i_blank_lz = 1'b1;
    i_nco_num  = '0;
    i_bright   = '1;

    repeat (3) @(negedge clk);
    check("rst_enb", 32'(o_seg_enb), 32'd0);
    check("rst_seg", 32'(o_seg), 32'd0);
    check("rst_dp", 32'(o_seg_dp), 32'd0);
    check("rst_fd", 32'(o_frame_done), 32'd0);
    i_nco_num = 32'h4000_0000;
    rst       = 1'b0;

    // Frame period and pulse width
    wait_frame();
    @(negedge clk);
    check("fd_width", 32'(o_frame_done), 32'd0);
    n = 1;
    while (o_frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_period", 32'(n), 32'd24);

    // Slot period
    @(negedge clk);
    e = o_seg_enb;
    check("slot0_enb", 32'(e), 32'd1);
    n = 0;
    while (o_seg_enb == e && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("slot_period", 32'(n), 32'd4);
    check("slot1_enb", 32'(o_seg_enb), 32'd2);

    // Leading-zero blanking of 0x012345
    do_load(24'h012345, 6'b000000);
    cap_frame();
    check_frame("lz", {7'h00, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B}, 6'b000000);

    // Two loads before a wrap: last write wins
    wait_frame();
    repeat (3) @(negedge clk);
    do_load(24'h111111, 6'b000000);
    repeat (2) @(negedge clk);
    do_load(24'hABCDEF, 6'b000000);
    cap_frame();
    check_frame("lww", {7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47}, 6'b000000);

    // Load coincident with the wrap tick
    i_blank_lz = 1'b0;
    wait_frame();
    repeat (23) @(negedge clk);
    do_load(24'h654321, 6'b000000);
    check("coinc_fd", 32'(o_frame_done), 32'd1);
    @(negedge clk);
    check("coinc_seg", 32'(o_seg), 32'h30);
    check("coinc_enb", 32'(o_seg_enb), 32'd1);

    // Decimal point stops blanking at digit 2
    i_blank_lz = 1'b1;
    wait_frame();
    repeat (3) @(negedge clk);
    do_load(24'h000000, 6'b000100);
    cap_frame();
    check_frame("dp", {7'h00, 7'h00, 7'h00, 7'h7E, 7'h7E, 7'h7E}, 6'b000100);

    // Brightness
    i_nco_num = 32'h1000_0000;
    i_bright  = 4'd4;
    repeat (40) @(negedge clk);
    count_on(n);
`ifdef SEG_DISP_PWM_EN
    check("pwm4_on", 32'(n), 32'd16);
`else
    check("pwm4_on", 32'(n), 32'd64);
`endif
    i_bright = 4'd0;
    repeat (8) @(negedge clk);
    count_on(n);
`ifdef SEG_DISP_PWM_EN
    check("pwm0_on", 32'(n), 32'd0);
`else
    check("pwm0_on", 32'(n), 32'd64);
`endif

    // Asynchronous reset mid-frame drops the pending load
    i_nco_num  = 32'h4000_0000;
    i_bright   = '1;
    i_blank_lz = 1'b0;
    wait_frame();
    repeat (3) @(negedge clk);
    do_load(24'h888888, 6'b111111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_enb", 32'(o_seg_enb), 32'd0);
    check("arst_seg", 32'(o_seg), 32'd0);
    check("arst_fd", 32'(o_frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cap_frame();
    check_frame("post_rst", {7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E}, 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
